moving_sum_engine: RTL and testbench
====================================

MOVING_SUM_ENGINE -- requirements
Module: moving_sum_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed input sample width.
REQ-002 SHALL have parameter DEPTH, default 16, window length; power of two, 2..1024.
REQ-003 SHALL derive localparam SUM_W = DATA_W + log2(DEPTH), the result width.
REQ-004 SHALL have port CLK100MHZ, input, 1, the single clock; all logic rises on it.
REQ-005 SHALL have port reset_in_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port mode, input, 1: 0 = sliding window, 1 = block (decimate by DEPTH).
REQ-007 SHALL have port clear, input, 1, synchronous flush of window contents and state.
REQ-008 SHALL have port s_axis_tvalid, input, 1, sample valid.
REQ-009 SHALL have port s_axis_tdata, input, DATA_W, signed sample.
REQ-010 SHALL have port s_axis_tready, output, 1, sample accepted when tvalid and tready are both high.
REQ-011 SHALL have port m_axis_tvalid, output, 1, result valid.
REQ-012 SHALL have port m_axis_tdata, output, SUM_W, signed window sum.
REQ-013 SHALL have port m_axis_tready, input, 1, result consumed.
REQ-014 SHALL have port busy, output, 1, high in FILL or RUN.

Function
REQ-015 SHALL implement FSM IDLE -> FILL on first accepted sample; FILL -> RUN after DEPTH accepted samples; any state -> IDLE on clear.
REQ-016 SHALL latch mode only on the IDLE->FILL transition; mode changes in FILL/RUN are ignored.
REQ-017 SHALL, per accepted sample, update sum = sum + new - oldest, with oldest read as 0 while in FILL (and for all of block mode).
REQ-018 SHALL store samples in a DEPTH-entry circular buffer; write pointer wraps from DEPTH-1 to 0.
REQ-019 SHALL, in sliding mode, present a result 1 cycle after each accepted sample once DEPTH samples are held (the DEPTH-th sample and every later one).
REQ-020 SHALL, in block mode, present a result 1 cycle after every DEPTH-th accepted sample, then zero the sum with no lost sample.
REQ-021 SHALL perform all arithmetic sign-extended to SUM_W; overflow cannot occur.
REQ-022 SHALL hold m_axis_tdata/m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 SHALL drive s_axis_tready = !clear && (!m_axis_tvalid || m_axis_tready), giving full throughput, no bubble.
REQ-024 SHALL give clear priority over a simultaneous sample: the sample is not accepted, and the pending result is dropped (m_axis_tvalid=0 next cycle).

Reset
REQ-025 SHALL on reset_in_n=0 immediately force state=IDLE, sum=0, pointers=0, fill count=0, m_axis_tvalid=0, m_axis_tdata=0, busy=0; s_axis_tready then reads 1.
REQ-026 SHALL not require buffer contents to be reset; FILL masking guarantees stale data never reaches the sum.
REQ-027 SHALL treat reset asserted mid-window as full abort; the first post-reset sample starts a new FILL.

Configuration
REQ-028 SHALL, with MOVING_SUM_AVG_EN defined, add output m_axis_tavg (DATA_W) = m_axis_tdata arithmetically shifted right by log2(DEPTH), qualified by m_axis_tvalid, reset 0.
REQ-029 SHALL, without MOVING_SUM_AVG_EN, omit the port and its logic entirely.

Structure
REQ-030 SHALL place the state enum (IDLE/FILL/RUN), mode constants and a clog2 helper in shared package moving_sum_pkg.
REQ-031 SHALL implement the circular buffer as sub-module moving_sum_ring_buf (1 write, 1 read of oldest, combinational read), inferable as distributed RAM.

Verification (DATA_W=8, DEPTH=4)
REQ-032 SHALL check sliding mode: inputs 1,2,3,4,5,6 back-to-back -> outputs 10,14,18, first one 1 cycle after sample 4.
REQ-033 SHALL check block mode: inputs 1..8 -> exactly two outputs, 10 then 26.
REQ-034 SHALL check signed extremes: sliding, four -128 then four 127 -> outputs -512, -257, -2, 253, 508; SUM_W=10, no wrap.
REQ-035 SHALL check backpressure: m_axis_tready low 5 cycles with a result pending -> s_axis_tready=0, output held, no sample lost.
REQ-036 SHALL check clear concurrent with tvalid after 3 samples -> sample dropped, IDLE; then 4,4,4,4 -> first output 16.
REQ-037 SHALL check reset pulse mid-RUN -> all outputs 0 asynchronously; refill of 2,2,2,2 yields 8; with MOVING_SUM_AVG_EN, m_axis_tavg=2.

Source files
------------

// File: rtl/moving_sum_pkg.sv
// moving_sum_pkg
// Shared types and helpers for the moving-sum engine.
//   state_t      : engine state (IDLE, FILL, RUN)
//   MODE_SLIDING : sliding-window mode (one result per sample once full)
//   MODE_BLOCK   : block mode (one result per DEPTH samples, then restart)
//   clog2()      : ceiling log2 for elaboration-time width derivation
package moving_sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic MODE_SLIDING = 1'b0;
  localparam logic MODE_BLOCK   = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/moving_sum_ring_buf.sv
// moving_sum_ring_buf
// DEPTH-entry sample store: one synchronous write port and one
// combinational read port. No reset on the array, so it maps onto
// distributed RAM.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module moving_sum_ring_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/moving_sum_engine.sv
// moving_sum_engine
// Streaming moving-sum over the last DEPTH signed samples (sliding mode)
// or over consecutive non-overlapping blocks of DEPTH samples (block mode).
// DEPTH must be a power of two in 2..1024.
// Optional feature macro: MOVING_SUM_AVG_EN adds m_axis_tavg, the window
// sum arithmetically shifted right by log2(DEPTH).
// Ports:
//   CLK100MHZ     : clock
//   reset_in_n    : asynchronous active-low reset
//   mode          : 0 sliding, 1 block; sampled when a new window starts
//   clear         : synchronous flush back to IDLE, drops any pending result
//   s_axis_*      : sample input stream
//   m_axis_*      : result output stream (SUM_W signed)
//   m_axis_tavg   : (MOVING_SUM_AVG_EN only) average of the window
//   busy          : high while in FILL or RUN
//
// state | meaning
// IDLE  | no samples held; next accepted sample latches mode
// FILL  | fewer than DEPTH samples held; oldest reads as 0
// RUN   | window full; sliding mode subtracts the oldest sample
module moving_sum_engine
  import moving_sum_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int SUM_W  = DATA_W + clog2(DEPTH)
) (
  input  logic                     CLK100MHZ,
  input  logic                     reset_in_n,
  input  logic                     mode,
  input  logic                     clear,
  input  logic                     s_axis_tvalid,
  input  logic signed [DATA_W-1:0] s_axis_tdata,
  output logic                     s_axis_tready,
  output logic                     m_axis_tvalid,
  output logic signed [SUM_W-1:0]  m_axis_tdata,
  input  logic                     m_axis_tready,
`ifdef MOVING_SUM_AVG_EN
  output logic signed [DATA_W-1:0] m_axis_tavg,
`endif
  output logic                     busy
);

  localparam int AW = clog2(DEPTH);

  state_t                   state;
  logic                     mode_q;
  logic [AW-1:0]            wr_ptr;
  logic signed [SUM_W-1:0]  sum;

  logic                     accept;
  logic                     eff_block;
  logic                     last;
  logic                     mask_old;
  logic                     emit;
  logic [DATA_W-1:0]        old_raw;
  logic signed [SUM_W-1:0]  new_ext;
  logic signed [SUM_W-1:0]  old_ext;
  logic signed [SUM_W-1:0]  sum_nxt;

  moving_sum_ring_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ring_buf (
    .clk   (CLK100MHZ),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (s_axis_tdata),
    .raddr (wr_ptr),
    .rdata (old_raw)
  );

  assign s_axis_tready = !clear && (!m_axis_tvalid || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign busy          = (state != IDLE);

  // In IDLE the mode input is live because this sample opens the window.
  assign eff_block = (state == IDLE) ? (mode == MODE_BLOCK) : (mode_q == MODE_BLOCK);

  // The write pointer also serves as the fill/block counter: both start at
  // zero on every new window and advance once per accepted sample.
  assign last     = (wr_ptr == AW'(DEPTH - 1));

  // Slot at wr_ptr holds the sample from DEPTH accepts ago; it is only
  // meaningful once the window is full and only subtracted when sliding.
  assign mask_old = (state != RUN) || eff_block;

  assign new_ext = {{AW{s_axis_tdata[DATA_W-1]}}, s_axis_tdata};
  assign old_ext = mask_old ? '0 : {{AW{old_raw[DATA_W-1]}}, old_raw};
  assign sum_nxt = sum + new_ext - old_ext;

  assign emit = accept && (last || ((state == RUN) && !eff_block));

  always_ff @(posedge CLK100MHZ or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state         <= IDLE;
      mode_q        <= MODE_SLIDING;
      wr_ptr        <= '0;
      sum           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (clear) begin
      state         <= IDLE;
      mode_q        <= MODE_SLIDING;
      wr_ptr        <= '0;
      sum           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        case (state)
          IDLE: begin
            mode_q <= mode;
            state  <= FILL;
          end
          FILL: if (last) state <= RUN;
          default: ;
        endcase
        if (emit) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= sum_nxt;
        end
        // Block mode restarts from zero right after publishing a result,
        // so the next accepted sample begins the following block.
        sum <= (eff_block && last) ? '0 : sum_nxt;
      end
    end
  end

`ifdef MOVING_SUM_AVG_EN
  // Upper DATA_W bits of the sum are exactly sum >>> log2(DEPTH).
  assign m_axis_tavg = m_axis_tdata[SUM_W-1:AW];
`endif

endmodule

// File: tb/tb_moving_sum_engine.sv
module tb_moving_sum_engine;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int SUM_W  = 10;

  logic                     CLK100MHZ;
  logic                     reset_in_n;
  logic                     mode;
  logic                     clear;
  logic                     s_axis_tvalid;
  logic signed [DATA_W-1:0] s_axis_tdata;
  logic                     s_axis_tready;
  logic                     m_axis_tvalid;
  logic signed [SUM_W-1:0]  m_axis_tdata;
  logic                     m_axis_tready;
  logic                     busy;
`ifdef MOVING_SUM_AVG_EN
  logic signed [DATA_W-1:0] m_axis_tavg;
`endif

  int total = 0;
  int bad   = 0;
  logic signed [SUM_W-1:0] exp_q[$];
  logic signed [SUM_W-1:0] exp_v;

  moving_sum_engine #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK100MHZ     (CLK100MHZ),
    .reset_in_n    (reset_in_n),
    .mode          (mode),
    .clear         (clear),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tready (m_axis_tready),
`ifdef MOVING_SUM_AVG_EN
    .m_axis_tavg   (m_axis_tavg),
`endif
    .busy          (busy)
  );

  initial begin
    CLK100MHZ = 1'b0;
    forever #5 CLK100MHZ = ~CLK100MHZ;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every completed output handshake pops one expected sum.
  always @(negedge CLK100MHZ) begin
    if (reset_in_n && m_axis_tvalid && m_axis_tready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got=%0d expected=none", m_axis_tdata);
      end else begin
        exp_v = exp_q.pop_front();
        if (m_axis_tdata !== exp_v) begin
          bad++;
          $display("FAIL result got=%0d expected=%0d", m_axis_tdata, exp_v);
        end
`ifdef MOVING_SUM_AVG_EN
        total++;
        if (m_axis_tavg !== exp_v[SUM_W-1:2]) begin
          bad++;
          $display("FAIL avg got=%0d expected=%0d", m_axis_tavg, $signed(exp_v[SUM_W-1:2]));
        end
`endif
      end
    end
  end

  task automatic push_exp(input int v);
    exp_q.push_back(SUM_W'(v));
  endtask

  task automatic send(input int v);
    int n;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DATA_W'(v);
    n = 0;
    @(negedge CLK100MHZ);
    while (!s_axis_tready && n < 50) begin
      n++;
      @(negedge CLK100MHZ);
    end
    if (!s_axis_tready) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=tready_low expected=accept value=%0d", v);
    end
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge CLK100MHZ);
    #1;
    clear = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge CLK100MHZ);
      n++;
    end
    repeat (3) @(negedge CLK100MHZ);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_%s got=%0d_left expected=0_left", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic test_reset();
    reset_in_n    = 1'b0;
    mode          = 1'b0;
    clear         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    #3;
    total++;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b expected=0", m_axis_tvalid); end
    total++;
    if (m_axis_tdata !== '0) begin bad++; $display("FAIL reset_tdata got=%0d expected=0", m_axis_tdata); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b expected=0", busy); end
    total++;
    if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%b expected=1", s_axis_tready); end
    repeat (2) @(posedge CLK100MHZ);
    #1;
    reset_in_n = 1'b1;
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic test_sliding();
    do_clear();
    mode = 1'b0;
    send(1); send(2); send(3);
    total++;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL sliding_early got=%b expected=0", m_axis_tvalid); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL sliding_busy got=%b expected=1", busy); end
    push_exp(10); send(4);
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== SUM_W'(10)) begin
      bad++;
      $display("FAIL sliding_latency got=%b/%0d expected=1/10", m_axis_tvalid, m_axis_tdata);
    end
    push_exp(14); send(5);
    push_exp(18); send(6);
    idle();
    drain("sliding");
  endtask

  task automatic test_block();
    do_clear();
    mode = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) push_exp(10);
      if (i == 8) push_exp(26);
      send(i);
    end
    idle();
    mode = 1'b0;
    drain("block");
  endtask

  task automatic test_extremes();
    int exp_list [5];
    exp_list = '{-512, -257, -2, 253, 508};
    do_clear();
    mode = 1'b0;
    send(-128); send(-128); send(-128);
    push_exp(exp_list[0]); send(-128);
    for (int i = 1; i < 5; i++) begin
      push_exp(exp_list[i]);
      send(127);
    end
    idle();
    drain("extremes");
  endtask

  task automatic test_backpressure();
    do_clear();
    mode = 1'b0;
    m_axis_tready = 1'b0;
    send(1); send(2); send(3);
    push_exp(10); send(4);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'sd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK100MHZ);
      total++;
      if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL bp_tready cycle=%0d got=%b expected=0", i, s_axis_tready); end
      total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== SUM_W'(10)) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got=%b/%0d expected=1/10", i, m_axis_tvalid, m_axis_tdata);
      end
    end
    @(posedge CLK100MHZ);
    #1;
    m_axis_tready = 1'b1;
    push_exp(14); send(5);
    idle();
    drain("backpressure");
  endtask

  task automatic test_clear();
    do_clear();
    mode = 1'b0;
    m_axis_tready = 1'b0;
    send(1); send(2); send(3); send(4);
    idle();
    total++;
    if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL clear_pending got=%b expected=1", m_axis_tvalid); end
    do_clear();
    total++;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL clear_drop got=%b expected=0", m_axis_tvalid); end
    m_axis_tready = 1'b1;
    send(1); send(2); send(3);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'sd9;
    clear = 1'b1;
    @(negedge CLK100MHZ);
    total++;
    if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL clear_tready got=%b expected=0", s_axis_tready); end
    @(posedge CLK100MHZ);
    #1;
    clear = 1'b0;
    idle();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL clear_idle got=%b expected=0", busy); end
    send(4); send(4); send(4);
    push_exp(16); send(4);
    idle();
    drain("clear");
  endtask

  task automatic test_mode_latch();
    do_clear();
    mode = 1'b0;
    send(1);
    mode = 1'b1;
    send(2); send(3);
    push_exp(10); send(4);
    push_exp(14); send(5);
    idle();
    mode = 1'b0;
    drain("mode_latch");
  endtask

  task automatic test_reset_midrun();
    do_clear();
    mode = 1'b0;
    send(1); send(2); send(3);
    push_exp(10); send(4);
    push_exp(14); send(5);
    idle();
    drain("pre_reset");
    m_axis_tready = 1'b0;
    send(6);
    idle();
    total++;
    if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL rst_pending got=%b expected=1", m_axis_tvalid); end
    #2;
    reset_in_n = 1'b0;
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_async_tvalid got=%b expected=0", m_axis_tvalid); end
    total++;
    if (m_axis_tdata !== '0) begin bad++; $display("FAIL rst_async_tdata got=%0d expected=0", m_axis_tdata); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b expected=0", busy); end
    total++;
    if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_async_tready got=%b expected=1", s_axis_tready); end
`ifdef MOVING_SUM_AVG_EN
    total++;
    if (m_axis_tavg !== '0) begin bad++; $display("FAIL rst_async_avg got=%0d expected=0", m_axis_tavg); end
`endif
    @(posedge CLK100MHZ);
    #1;
    reset_in_n = 1'b1;
    @(posedge CLK100MHZ);
    #1;
    m_axis_tready = 1'b1;
    send(2); send(2); send(2);
    push_exp(8); send(2);
    idle();
    drain("refill");
  endtask

  initial begin
    test_reset();
    test_sliding();
    test_block();
    test_extremes();
    test_backpressure();
    test_clear();
    test_mode_latch();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
